muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file.
//  Consumes RD1/RD2 as op_a/op_b on start and runs a multi-cycle shift-add / restoring-divide datapath.
//  Returns result + destination index to the writeback path that drives WD3/AD3/WE3.
//  Pipeline control stalls decode while busy is high.
// PARAMETERS
//  XLEN     32  operand/result width (power of 2, >=8)
//  REG_AW   5   register index width (matches register file address width)
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       synchronous active-low reset
//  start    in   1       request; sampled only in IDLE
//  funct3   in   3       RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op_a     in   XLEN    rs1 value (RD1)
//  op_b     in   XLEN    rs2 value (RD2)
//  rd_in    in   REG_AW  destination register index
//  busy     out  1       high in CALC and DONE; start is ignored while high
//  done     out  1       one-cycle pulse; result/rd_out/we_out valid this cycle
//  result   out  XLEN    result; holds until next accepted start
//  rd_out   out  REG_AW  latched rd_in
//  we_out   out  1       equals done AND (rd_out != 0); x0 is never written
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; busy, done, we_out=0; result, rd_out, counter=0.
//  Reset is honoured in any state; an in-flight operation is discarded with no done pulse.
//  FSM: IDLE -(start)-> CALC -(count==XLEN-1)-> DONE -> IDLE; IDLE -(start & special)-> DONE.
//  Accept: in IDLE with start=1, latch funct3, rd_in, |op_a|, |op_b| and sign flags; counter=0.
//  Signedness:
//   - MULH/DIV/REM treat both operands as signed.
//   - MULHSU treats op_a as signed, op_b as unsigned; the rest are unsigned.
//   - Core arithmetic is always unsigned on magnitudes; a sign correction is applied on DONE entry.
//  MUL*: one shift-add step per CALC cycle into a 2*XLEN accumulator.
//   - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//  DIV*/REM*: one restoring step per CALC cycle (shift remainder, trial subtract, set quotient bit).
//   - Quotient sign is sign(a) XOR sign(b); remainder sign follows dividend.
//  Latency: start high in cycle 0 -> done in cycle XLEN+1 (33 at default).
//  Special cases skip CALC, done in cycle 1:
//   - divide by zero: DIV/DIVU -> all-ones; REM/REMU -> op_a.
//   - signed overflow (op_a=-2^(XLEN-1), op_b=-1): DIV -> op_a; REM -> 0.
//  Boundaries and handshake:
//   - start in CALC/DONE is dropped (not queued); upstream must hold the request until busy=0.
//   - No back-to-back accept in the done cycle; the earliest next accept is the cycle after done.
//   - Operand inputs may change freely after the accept cycle.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   - MUL* compute with a single-cycle '*' on sign-extended XLEN+1 operands.
//   - IDLE -(start & MUL*)-> DONE, so done arrives in cycle 1; divides are unchanged.
//  Undefined: all ops use the iterative path and the latency above; no multiplier is inferred.
// STRUCTURE
//  muldiv_pkg (shared):
//   - funct3 enum muldiv_op_e.
//   - state enum muldiv_state_e {IDLE, CALC, DONE}.
//   - XLEN-derived localparams (counter width $clog2(XLEN)).
//  Sub-module muldiv_sign_ctrl (combinational):
//   - operand magnitude/sign extraction and final two's-complement correction.
//  The FSM, counter, accumulator and quotient/remainder registers live in this module.
// TESTING
//  MUL 7*-3, rd=5 -> done cycle 33, result=0xFFFFFFEB, rd_out=5, we_out=1.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> -3; REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2; all done in cycle 33.
//  DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done in cycle 1;
//   DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, done in cycle 1.
//  start pulsed in cycle 10 of a running op -> ignored, single done;
//   rst_n=0 in cycle 15 -> no done, busy=0, result=0 next cycle.
//  rd_in=0 with MUL 3*4 -> done=1, result=12, we_out=0;
//   with MULDIV_FAST_MUL_EN -> same result, done in cycle 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states,
// default widths and operand-signedness helpers.
package muldiv_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic int muldiv_cnt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_ctrl.sv
// Combinational sign handling: operand magnitude/sign extraction on accept, and
// two's-complement correction of the unsigned core result on DONE entry.
module muldiv_sign_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  muldiv_op_e        in_op_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              sign_a_o,
  output logic              sign_b_o,
  input  muldiv_op_e        res_op_i,
  input  logic              res_sign_a_i,
  input  logic              res_sign_b_i,
  input  logic [2*XLEN-1:0] raw_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    sign_a_o = op_a_signed(in_op_i) & op_a_i[XLEN-1];
    sign_b_o = op_b_signed(in_op_i) & op_b_i[XLEN-1];
    mag_a_o  = sign_a_o ? -op_a_i : op_a_i;
    mag_b_o  = sign_b_o ? -op_b_i : op_b_i;

    // raw_i holds the full product for MUL*, or {remainder, quotient} for DIV*/REM*
    prod = (res_sign_a_i ^ res_sign_b_i) ? -raw_i : raw_i;
    quo  = (res_sign_a_i ^ res_sign_b_i) ? -raw_i[XLEN-1:0] : raw_i[XLEN-1:0];
    rem  = res_sign_a_i ? -raw_i[2*XLEN-1:XLEN] : raw_i[2*XLEN-1:XLEN];

    case (res_op_i)
      OP_MUL:                       res_o = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_o = quo;
      default:                      res_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: one shift-add or restoring-divide step per cycle, done XLEN+1 cycles
// after accept (1 for div-by-zero/overflow); start is dropped while busy. MULDIV_FAST_MUL_EN: single-cycle MUL*.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [REG_AW-1:0] rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out,
  output logic              we_out
);

  localparam int CNT_W = muldiv_cnt_w(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  muldiv_op_e        in_op;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;
  logic              in_sa, in_sb;
  logic [XLEN-1:0]   fixed_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift, trial;
  logic [2*XLEN-1:0] step_acc;
  logic              special;
  logic [XLEN-1:0]   special_res;

  assign in_op = muldiv_op_e'(funct3);

  muldiv_sign_ctrl #(.XLEN(XLEN)) u_sign (
    .in_op_i      (in_op),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .mag_a_o      (in_mag_a),
    .mag_b_o      (in_mag_b),
    .sign_a_o     (in_sa),
    .sign_b_o     (in_sb),
    .res_op_i     (op_q),
    .res_sign_a_i (sa_q),
    .res_sign_b_i (sb_q),
    .raw_i        (step_acc),
    .res_o        (fixed_res)
  );

  // One datapath step. Multiply: acc = {partial, multiplier} shifting right.
  // Divide: acc = {remainder, dividend/quotient} shifting left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    trial     = rem_shift - {1'b0, mag_b_q};
    if (!op_q[2]) begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end else if (trial[XLEN]) begin
      step_acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_acc = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (funct3[2] && (op_b == '0)) begin
      special     = 1'b1;
      special_res = funct3[1] ? op_a : '1;
    end else if ((in_op == OP_DIV || in_op == OP_REM) &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : op_a;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     fast_a, fast_b;
  logic [2*XLEN+1:0] fast_p;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_a   = {in_sa, op_a};
    fast_b   = {in_sb, op_b};
    fast_p   = $signed({{(XLEN+1){fast_a[XLEN]}}, fast_a}) *
               $signed({{(XLEN+1){fast_b[XLEN]}}, fast_b});
    fast_res = (in_op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = in_op;
          rd_d    = rd_in;
          sa_d    = in_sa;
          sb_d    = in_sb;
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          acc_d   = funct3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
          cnt_d   = '0;
          if (special) begin
            res_d   = special_res;
            state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!funct3[2]) begin
            res_d   = fast_res;
            state_d = DONE;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = fixed_res;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign rd_out = rd_q;
  assign we_out = done && (rd_q != '0);

endmodule
